// File: rtl/cond_inv_sched.sv
// Scheduler for a shared conditional-inversion stage serving two requesters.
// Define COND_INV_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module cond_inv_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             inv0,
  input  logic             inv1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] stage_a,
  output logic [WIDTH-1:0] stage_b,
  output logic             stage_pwr_en,
  input  logic [WIDTH-1:0] stage_out,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHARGE  = 3'd1,
    EVAL    = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_gnt;
  logic             w_gnt_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_pick1;
  logic             w_grant;
  logic             w_stage_on;

  logic             r_ack0;
  logic             r_ack1;
  logic [WIDTH-1:0] r_rsp;
  logic [WIDTH-1:0] r_stage_a;
  logic [WIDTH-1:0] r_stage_b;
  logic             r_pwr;
  logic             r_busy;

  assign w_grant = (r_state == IDLE) && (req0 || req1);

`ifdef COND_INV_SCHED_FIXED_PRIO_EN
  assign w_pick1 = req1 && !req0;
`else
  // Last granted requester; reset to 1 so requester 0 wins the first contention.
  logic r_last;

  assign w_pick1 = req1 && (!req0 || !r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_pick1;
    end
  end
`endif

  // Next-state and operand capture
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = CHARGE;
          w_gnt_nxt   = w_pick1;
          w_a_nxt     = w_pick1 ? a1 : a0;
          w_b_nxt     = {WIDTH{w_pick1 ? inv1 : inv0}};
        end
      end
      CHARGE:  w_state_nxt = EVAL;
      EVAL:    w_state_nxt = HOLD;
      HOLD:    w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_stage_on = (w_state_nxt == CHARGE) || (w_state_nxt == EVAL) ||
                 (w_state_nxt == HOLD);
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rsp     <= '0;
      r_stage_a <= '0;
      r_stage_b <= '0;
      r_pwr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_pwr     <= w_stage_on;
      r_stage_a <= w_stage_on ? w_a_nxt : '0;
      r_stage_b <= w_stage_on ? w_b_nxt : '0;
      r_busy    <= (w_state_nxt != IDLE);
      r_ack0    <= (w_state_nxt == RECOVER) && !w_gnt_nxt;
      r_ack1    <= (w_state_nxt == RECOVER) && w_gnt_nxt;
      // Stage result captured at the end of HOLD, presented during RECOVER.
      r_rsp     <= (w_state_nxt == RECOVER) ? stage_out : '0;
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign rsp_data     = r_rsp;
  assign stage_a      = r_stage_a;
  assign stage_b      = r_stage_b;
  assign stage_pwr_en = r_pwr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_cond_inv_sched.sv
// Scoreboard bench for cond_inv_sched; the stage is modelled as stage_a ^ stage_b.
module tb_cond_inv_sched;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, inv0, inv1;
  logic [WIDTH-1:0] a0, a1;
  logic             ack0, ack1, stage_pwr_en, busy;
  logic [WIDTH-1:0] rsp_data, stage_a, stage_b, stage_out;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign stage_out = stage_a ^ stage_b;

  cond_inv_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1), .inv0(inv0), .inv1(inv1),
    .ack0(ack0), .ack1(ack1), .rsp_data(rsp_data),
    .stage_a(stage_a), .stage_b(stage_b), .stage_pwr_en(stage_pwr_en),
    .stage_out(stage_out), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sbq.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever an ack appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (ack0 && ack1) begin
          chk("dual_ack", {30'd0, ack1, ack0}, 32'd1);
        end else if (sbq.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("ack_id", {31'd0, ack1}, {31'd0, e.id});
          chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; inv0 = 1'b0; inv1 = 1'b0;
    a0 = '0; a1 = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pwr", {31'd0, stage_pwr_en}, 32'd0);
    chk("rst_outs", {ack0, ack1, rsp_data, 14'd0}, 32'd0);
    chk("rst_stage", {stage_a, stage_b}, 32'd0);

    // Inverting op from requester 0, first cycle out of reset.
    rst = 1'b0;
    req0 = 1'b1; a0 = 16'h00FF; inv0 = 1'b1; push(1'b0, 16'hFF00);
    tick(); req0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("s1_pwr", {31'd0, stage_pwr_en}, 32'd1);
      chk("s1_stage", {stage_a, stage_b}, 32'h00FF_FFFF);
      tick();
    end
    chk("s1_ack_cycle", {30'd0, ack0, stage_pwr_en}, 32'd2);
    tick();
    chk("s1_idle", {31'd0, busy}, 32'd0);

    // Pass-through op from requester 1.
    req1 = 1'b1; a1 = 16'h1234; inv1 = 1'b0; push(1'b1, 16'h1234);
    tick(); req1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("s2_stage_b", {16'd0, stage_b}, 32'd0);
      chk("s2_pwr", {31'd0, stage_pwr_en}, (c < 4) ? 32'd1 : 32'd0);
      chk("s2_ack1", {31'd0, ack1}, (c == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // req0 drops in CHARGE, operand changes in EVAL: original result returned.
    req0 = 1'b1; a0 = 16'h0F0F; inv0 = 1'b1; push(1'b0, 16'hF0F0);
    tick(); req0 = 1'b0;
    tick(); a0 = 16'hFFFF; inv0 = 1'b0;
    tick(); tick();
    chk("s5_ack0", {31'd0, ack0}, 32'd1);
    chk("s5_rsp", {16'd0, rsp_data}, 32'h0000_F0F0);
    tick();

    // Reset during EVAL aborts with no ack.
    req0 = 1'b1; a0 = 16'hAAAA; inv0 = 1'b0;
    tick(); req0 = 1'b0;
    tick();
    chk("s4_busy_eval", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("s4_abort", {29'd0, busy, stage_pwr_en, ack0}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("s4_no_ack", {31'd0, ack0}, 32'd0);
    end
    req0 = 1'b1; a0 = 16'h5555; inv0 = 1'b1; push(1'b0, 16'hAAAA);
    tick(); req0 = 1'b0;
    tick(); tick(); tick();
    chk("s4_resume_ack", {31'd0, ack0}, 32'd1);
    tick();

    // Both requesters held high after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; a0 = 16'h0001; inv0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0002; inv1 = 1'b1;
`ifdef COND_INV_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push(1'b0, 16'h0001);
`else
    push(1'b0, 16'h0001); push(1'b1, 16'hFFFD);
    push(1'b0, 16'h0001); push(1'b1, 16'hFFFD);
`endif
    for (int k = 1; k <= 19; k++) begin
      tick();
`ifdef COND_INV_SCHED_FIXED_PRIO_EN
      chk("s3_acks", {30'd0, ack1, ack0}, (k % 5 == 4) ? 32'd1 : 32'd0);
`else
      chk("s3_acks", {30'd0, ack1, ack0},
          (k % 10 == 4) ? 32'd1 : ((k % 10 == 9) ? 32'd2 : 32'd0));
`endif
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    chk("s3_idle", {31'd0, busy}, 32'd0);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_inv_sched.md
COND_INV_SCHED -- requirements
Module: cond_inv_sched

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the ports req0 and req1, input, 1 bit each: the operation request from requester 0 and requester 1.
REQ-005 The block SHALL have the ports a0 and a1, input, WIDTH bits each: the operand of each requester.
REQ-006 The block SHALL have the ports inv0 and inv1, input, 1 bit each: 1 invert the operand, 0 pass it through.
REQ-007 The block SHALL have the ports ack0 and ack1, output, 1 bit each: one-cycle response strobe to each requester.
REQ-008 The block SHALL have the port rsp_data, output, WIDTH bits: the result, valid only while ack0 or ack1 is high.
REQ-009 The block SHALL have the ports stage_a and stage_b, output, WIDTH bits each: the a and b operands of the shared 16-bit conditional-inversion stage.
REQ-010 The block SHALL have the port stage_pwr_en, output, 1 bit: the gate enabling the stage's clkpos/clkneg power clocks.
REQ-011 The block SHALL have the port stage_out, input, WIDTH bits: the stage result, equal to stage_a XOR stage_b once evaluated.
REQ-012 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, CHARGE, EVAL, HOLD and RECOVER, with every state except IDLE lasting exactly one cycle.
REQ-014 The block SHALL transition IDLE->CHARGE in a cycle where req0 or req1 is high, and otherwise remain in IDLE.
REQ-015 On the IDLE->CHARGE transition the block SHALL register the grant index, the granted operand a, and the granted inv bit replicated WIDTH times.
REQ-016 The block SHALL sequence CHARGE->EVAL->HOLD->RECOVER->IDLE unconditionally.
REQ-017 The block SHALL drive stage_pwr_en=1 in CHARGE, EVAL and HOLD, and 0 in IDLE and RECOVER.
REQ-018 The block SHALL drive stage_a and stage_b with the registered values in CHARGE, EVAL and HOLD, and with 0 otherwise.
REQ-019 The block SHALL capture stage_out into the result register at the end of HOLD.
REQ-020 The block SHALL assert ack of the granted requester for exactly the RECOVER cycle, with rsp_data equal to the captured result.
REQ-021 The block SHALL drive rsp_data to 0 outside RECOVER.
REQ-022 The latency SHALL be: request sampled in IDLE at cycle N -> ack at cycle N+4, with the next grant possible at cycle N+5.
REQ-023 Arbitration SHALL be round-robin: when both requests are high, grant the requester not granted most recently; the pointer updates on every grant.
REQ-024 When only one request is high, the block SHALL grant that requester regardless of the pointer.
REQ-025 A requester SHALL hold its req, a and inv stable until its ack; the block SHALL ignore changes to a and inv after the grant.
REQ-026 If req drops mid-operation, the block SHALL still complete the operation and issue the ack.
REQ-027 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-028 The block SHALL never issue more than one ack per grant, and never assert ack0 and ack1 in the same cycle.

Reset
REQ-029 While rst is high, the block SHALL set the state to IDLE, set the round-robin pointer so that requester 0 wins the first contention, and drive all outputs to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no ack issued and stage_pwr_en=0 from the next cycle.
REQ-031 Requests SHALL be sampled from the first cycle after rst deasserts.

Configuration
REQ-032 With COND_INV_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, with requester 0 always winning contention and the round-robin pointer removed.
REQ-033 Without COND_INV_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-023.
REQ-034 Timing and the state machine SHALL be identical in both configurations.

Verification
REQ-035 Bench scenario: req0=1, a0=16'h00FF, inv0=1 at cycle 0 (stage model XOR) -> stage_pwr_en high cycles 1-3, ack0 at cycle 4, rsp_data=16'hFF00.
REQ-036 Bench scenario: req1=1, a1=16'h1234, inv1=0 -> ack1 at +4, rsp_data=16'h1234, stage_b=0 throughout.
REQ-037 Bench scenario: req0 and req1 held high continuously after reset -> acks alternate 0,1,0,1 every 5 cycles (round-robin); with the macro defined -> ack0 only.
REQ-038 Bench scenario: rst pulsed in EVAL -> no ack, busy=0 and stage_pwr_en=0 the next cycle; a subsequent req0 is served normally.
REQ-039 Bench scenario: req0 drops in CHARGE and a0 changes in EVAL -> ack0 still at +4 carrying the originally sampled result.
